// File: rtl/icache_line_fill.sv
// icache_line_fill: instruction-cache refill engine; one line-aligned memory read, BEAT_COUNT beats, one-cycle cache write
// Ports: clk/arst (async active-high reset); i_miss/i_miss_addr start a fill from IDLE; o_busy while not IDLE;
// o_mem_req/i_mem_req_ready/o_mem_addr request handshake; i_mem_rvalid/i_mem_rdata/o_mem_rready read beats;
// o_cache_we/o_cache_addr/o_cache_line cache write port.
// Optional macro ICACHE_FILL_ERR_EN adds i_mem_rerr/o_fill_err: an errored fill pulses o_fill_err instead of o_cache_we.
module icache_line_fill #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int BEAT_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   arst,
`ifdef ICACHE_FILL_ERR_EN
    input  logic                   i_mem_rerr,
    output logic                   o_fill_err,
`endif
    input  logic                   i_miss,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_busy,
    output logic                   o_mem_req,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_rvalid,
    input  logic [BEAT_WIDTH-1:0]  i_mem_rdata,
    output logic                   o_mem_rready,
    output logic                   o_cache_we,
    output logic [ADDR_WIDTH-1:0]  o_cache_addr,
    output logic [BLOCK_WIDTH-1:0] o_cache_line
);
    localparam int BEAT_COUNT = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int LINE_OFF_W = $clog2(BLOCK_WIDTH / 8);
    localparam int CNT_W      = $clog2(BEAT_COUNT);

    typedef enum logic [1:0] {IDLE, REQ, DATA, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] line_q, line_d;
    logic                   beat;
    logic                   unused_off;
`ifdef ICACHE_FILL_ERR_EN
    logic                   err_q, err_d;
`endif

    // Byte offset within the line is dropped when the address is latched.
    assign unused_off = ^i_miss_addr[LINE_OFF_W-1:0];
    assign beat       = (state_q == DATA) && i_mem_rvalid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
`ifdef ICACHE_FILL_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (i_miss) begin
                state_d = REQ;
                addr_d  = {i_miss_addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
`ifdef ICACHE_FILL_ERR_EN
                err_d   = 1'b0;
`endif
            end
            REQ: state_d = i_mem_req_ready ? DATA : REQ;
            DATA: if (beat) begin
                line_d[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH] = i_mem_rdata;
                // Natural wrap to 0 coincides with the last beat of the line.
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(BEAT_COUNT - 1)) ? WRITE : DATA;
`ifdef ICACHE_FILL_ERR_EN
                err_d   = err_q | i_mem_rerr;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
`ifdef ICACHE_FILL_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
`ifdef ICACHE_FILL_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_busy       = state_q != IDLE;
    assign o_mem_req    = state_q == REQ;
    assign o_mem_rready = state_q == DATA;
    assign o_mem_addr   = addr_q;
    assign o_cache_addr = addr_q;
    assign o_cache_line = line_q;
`ifdef ICACHE_FILL_ERR_EN
    assign o_cache_we   = (state_q == WRITE) && !err_q;
    assign o_fill_err   = (state_q == WRITE) && err_q;
`else
    assign o_cache_we   = state_q == WRITE;
`endif
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: table-driven fills with an expected-write scoreboard for icache_line_fill
module tb_icache_line_fill;
    logic         clk = 1'b0;
    logic         arst, miss, ready, rvalid, rerr, fill_err;
    logic [63:0]  miss_addr, rdata, mem_addr, cache_addr;
    logic         busy, mem_req, rready, cache_we;
    logic [511:0] cache_line;
    int           checks = 0, passed = 0, cyc = 0, we_cyc = 0;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] line;
        bit           err;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [63:0] addr;
        logic [63:0] exp_addr;
        logic [63:0] base;
        int          stall;
        int          gap;
        bit          busy_miss;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    icache_line_fill dut (
        .clk(clk),
        .arst(arst),
`ifdef ICACHE_FILL_ERR_EN
        .i_mem_rerr(rerr),
        .o_fill_err(fill_err),
`endif
        .i_miss(miss),
        .i_miss_addr(miss_addr),
        .o_busy(busy),
        .o_mem_req(mem_req),
        .i_mem_req_ready(ready),
        .o_mem_addr(mem_addr),
        .i_mem_rvalid(rvalid),
        .i_mem_rdata(rdata),
        .o_mem_rready(rready),
        .o_cache_we(cache_we),
        .o_cache_addr(cache_addr),
        .o_cache_line(cache_line)
    );

`ifndef ICACHE_FILL_ERR_EN
    assign fill_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Advance one cycle, sample #1 after the edge, and score any write-port event.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cache_we || fill_err) begin
            we_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_write", {cache_we, fill_err}, 2'b00);
            else begin
                e = sb.pop_front();
                chk("write_we", cache_we, !e.err);
                chk("write_err", fill_err, e.err);
                chk("write_addr", cache_addr, e.addr);
                if (!e.err) chk("write_line", cache_line, e.line);
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_req"}, mem_req, 0);
        chk({name, "_rready"}, rready, 0);
        chk({name, "_we"}, {cache_we, fill_err}, 0);
        chk({name, "_addrs"}, {mem_addr, cache_addr}, 0);
        chk({name, "_line"}, cache_line, 0);
    endtask

    task automatic do_fill(input logic [63:0] addr, input logic [63:0] exp_addr, input logic [63:0] base,
                           input int stall, input int gap, input bit busy_miss, input int abort_at,
                           input int err_beat);
        logic [511:0] line;
        int start, n;
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("idle_before_fill", busy, 0);
        for (int k = 0; k < 8; k++) line[k*64 +: 64] = base + 64'(k);
        if (abort_at >= 8) sb.push_back('{exp_addr, line, err_beat >= 0});
        miss = 1; miss_addr = addr; start = cyc;
        step();
        miss = 0; miss_addr = ~addr;
        chk("req_valid", mem_req, 1);
        chk("req_addr", mem_addr, exp_addr);
        chk("req_busy", busy, 1);
        rvalid = 1; rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, exp_addr);
        end
        ready = 1;
        step();
        ready = 0; rvalid = 0;
        chk("data_rready", rready, 1);
        for (int k = 0; k < 8; k++) begin
            if (gap != 0 && k > 0) begin rvalid = 0; step(); chk("gap_rready", rready, 1); end
            rvalid = 1; rdata = base + 64'(k); rerr = (k == err_beat);
            if (busy_miss && k == 3) begin miss = 1; miss_addr = 64'h8000; end
            step();
            miss = 0; rerr = 0;
            if (k + 1 == abort_at) begin
                rvalid = 0; arst = 1;
                #1;
                chk_zero("midreset");
                repeat (3) step();
                chk_zero("midreset_hold");
                arst = 0;
                repeat (2) step();
                chk("after_abort_idle", busy, 0);
                return;
            end
        end
        rvalid = 0;
        chk("write_latency", we_cyc - start, 10 + stall + 7 * gap);
        chk("write_rready", rready, 0);
        chk("write_mem_addr", mem_addr, exp_addr);
        step();
        chk("back_idle", {busy, cache_we, fill_err}, 0);
        chk("hold_addr", cache_addr, exp_addr);
        chk("hold_line", cache_line, line);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{64'h1234, 64'h1200, 64'h1111_1111_1111_1110, 0, 0, 1'b0};
        tbl[1] = '{64'hDEAD_BEEF_0000_007F, 64'hDEAD_BEEF_0000_0040, 64'hA5A5_0000_C3C3_0000, 3, 1, 1'b0};
        tbl[2] = '{64'h3000, 64'h3000, 64'h0F0F_0F0F_0000_0100, 0, 0, 1'b1};
        tbl[3] = '{64'h8000, 64'h8000, 64'h8000_0000_0000_0800, 1, 0, 1'b0};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 64'h7777_6666_5555_4440, 0, 1, 1'b0};
        arst = 1; miss = 0; ready = 0; rvalid = 0; rerr = 0; miss_addr = '0; rdata = '0;
        repeat (2) step();
        chk_zero("reset");
        arst = 0;
        step();
        chk("reset_idle", busy, 0);
        for (int i = 0; i < 5; i++)
            do_fill(tbl[i].addr, tbl[i].exp_addr, tbl[i].base, tbl[i].stall, tbl[i].gap,
                    tbl[i].busy_miss, 8, -1);
        do_fill(64'h0555, 64'h0540, 64'h2222_0000_0000_0000, 0, 0, 1'b0, 4, -1);
        do_fill(64'h0040, 64'h0040, 64'h4040_4040_4040_4040, 0, 0, 1'b0, 8, -1);
`ifdef ICACHE_FILL_ERR_EN
        do_fill(64'h0900, 64'h0900, 64'h9999_0000_0000_0000, 0, 0, 1'b0, 8, 3);
        do_fill(64'h0A00, 64'h0A00, 64'hAAAA_0000_0000_0000, 0, 1, 1'b0, 8, -1);
`endif
        repeat (3) step();
        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
